// File: rtl/arith_logic_unit.sv
// arith_logic_unit: registered Nandgame-style ALU, ripple-carry arithmetic, logic unit, zr/ng flags
module arith_logic_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             u,
  input  logic             op1,
  input  logic             op0,
  input  logic             zx,
  input  logic             sw,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] xs, ys, xm, b, sum, lg, res;
  logic [WIDTH-1:0] c;
  assign xs = sw ? Y : X;
  assign ys = sw ? X : Y;
  assign xm = zx ? '0 : xs;
  assign b = op0 ? {WIDTH{op1}} : (op1 ? ~ys : ys);
  assign c[0] = op1 ^ op0;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i] = xm[i] ^ b[i] ^ c[i];
      if (i < WIDTH - 1) begin : g_c
        assign c[i+1] = (xm[i] & b[i]) | (c[i] & (xm[i] ^ b[i]));
      end
    end
  endgenerate
  assign lg = op1 ? (op0 ? ~xm : xm ^ ys) : (op0 ? xm | ys : xm & ys);
  assign res = u ? sum : lg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      zr <= 1'b0;
      ng <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= res;
        zr <= res == '0;
        ng <= res[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_arith_logic_unit.sv
// tb_arith_logic_unit: scoreboard bench, random and directed vectors against a behavioural ALU model
module tb_arith_logic_unit;
  typedef struct packed {
    logic [15:0] o;
    logic        z;
    logic        n;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] X = '0, Y = '0;
  logic        u = 1'b0, op1 = 1'b0, op0 = 1'b0, zx = 1'b0, sw = 1'b0;
  logic [15:0] out;
  logic        out_valid, zr, ng;
  exp_t        q[$];
  exp_t        held = '0;
  int          passed = 0, total = 0;
  arith_logic_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .X(X), .Y(Y), .u(u),
    .op1(op1), .op0(op0), .zx(zx), .sw(sw), .out(out), .out_valid(out_valid),
    .zr(zr), .ng(ng)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
  endtask
  function automatic exp_t model(input logic [15:0] x, y, input logic ua, o1, o0, z, s);
    int a, bb, r;
    exp_t e;
    a = s ? int'(y) : int'(x);
    bb = s ? int'(x) : int'(y);
    if (z) a = 0;
    case ({ua, o1, o0})
      3'b000: r = a & bb;
      3'b001: r = a | bb;
      3'b010: r = a ^ bb;
      3'b011: r = ~a;
      3'b100: r = a + bb;
      3'b101: r = a + 1;
      3'b110: r = a - bb;
      default: r = a - 1;
    endcase
    r = r & 32'hFFFF;
    e.o = 16'(r);
    e.z = r == 0;
    e.n = r >= 32'h8000;
    return e;
  endfunction
  task automatic issue(input logic [15:0] x, y, input logic ua, o1, o0, z, s);
    @(negedge clk);
    #1;
    X = x; Y = y; u = ua; op1 = o1; op0 = o0; zx = z; sw = s;
    in_valid = 1'b1;
    q.push_back(model(x, y, ua, o1, o0, z, s));
  endtask
  task automatic idle();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    {X, Y} = $urandom;
    {u, op1, op0, zx, sw} = 5'($urandom);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) begin
        held = q.pop_front();
        chk("out_valid", 32'(out_valid), 1);
        chk("out", 32'(out), 32'(held.o));
        chk("zr", 32'(zr), 32'(held.z));
        chk("ng", 32'(ng), 32'(held.n));
      end else begin
        chk("idle_valid", 32'(out_valid), 0);
        chk("hold_out", 32'(out), 32'(held.o));
        chk("hold_flags", 32'({zr, ng}), 32'({held.z, held.n}));
      end
    end
  end
  initial begin
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_flags", 32'({out_valid, zr, ng}), 0);
    #20 rst_n = 1'b1;
    issue(16'h0007, 16'h0004, 1, 0, 0, 0, 0);
    issue(16'h0007, 16'h0004, 1, 1, 0, 0, 0);
    issue(16'h0007, 16'h0004, 1, 1, 0, 1, 0);
    issue(16'h0007, 16'h0004, 1, 1, 0, 0, 1);
    issue(16'h0007, 16'h0004, 1, 1, 0, 1, 1);
    issue(16'h0000, 16'hFFFF, 0, 0, 0, 0, 0);
    issue(16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0);
    issue(16'h0001, 16'h00B1, 0, 0, 0, 0, 0);
    issue(16'h00F0, 16'h0F0F, 0, 0, 1, 0, 0);
    issue(16'h00F0, 16'h0F0F, 0, 1, 0, 0, 0);
    issue(16'h00F0, 16'h0F0F, 0, 1, 1, 0, 0);
    issue(16'hFFFF, 16'h1234, 1, 0, 1, 0, 0);
    issue(16'h0000, 16'h1234, 1, 1, 1, 0, 0);
    issue(16'hFFFF, 16'h0001, 1, 0, 0, 0, 0);
    idle();
    idle();
    issue(16'h8000, 16'h0000, 0, 0, 1, 0, 0);
    idle();
    idle();
    issue(16'h1234, 16'h4321, 1, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    q.delete();
    held = '0;
    #1;
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_flags", 32'({out_valid, zr, ng}), 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle();
    issue(16'h0007, 16'h0004, 1, 0, 0, 0, 0);
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle();
    idle();
    idle();
    chk("drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
